// File: rtl/cpu_control_unit.sv
// Instruction sequencer: fetches 4-bit opcodes from a combinational ROM and drives the A/B/ALU/answer datapath strobes.
// Optional single-step mode (PAUSE state and a step input) is enabled with `define CU_SINGLE_STEP_EN.
module cpu_control_unit #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] rom_data,
    output logic [3:0] rom_addr,
    output logic [3:0] IRCU,
    output logic       Aload,
    output logic       Bload,
    output logic       ANSload,
    output logic       A_select,
    output logic       B_select,
    output logic [1:0] select_mode,
    output logic       busy,
    output logic       done,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
`ifdef CU_SINGLE_STEP_EN
        S_DONE  = 3'd3,
        S_PAUSE = 3'd4
`else
        S_DONE  = 3'd3
`endif
    } state_t;

    localparam logic [3:0] OP_HALT = 4'b1001;
    localparam logic [3:0] OP_JMP0 = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1000;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pc;
    logic [3:0] w_pc_nxt;
    logic [3:0] r_ir;
    logic [3:0] w_ir_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= OP_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = rom_data;
                w_pc_nxt    = r_pc + 4'd1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (r_ir == OP_HALT) begin
                    w_state_nxt = S_DONE;
                end else begin
                    if (r_ir == OP_JMP0) begin
                        w_pc_nxt = RESET_PC;
                    end
`ifdef CU_SINGLE_STEP_EN
                    w_state_nxt = S_PAUSE;
`else
                    w_state_nxt = S_FETCH;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    w_state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs: strobes only decode the IR while in EXEC.
    always_comb begin
        Aload       = 1'b0;
        Bload       = 1'b0;
        ANSload     = 1'b0;
        A_select    = 1'b0;
        B_select    = 1'b0;
        select_mode = 2'b00;
        if (r_state == S_EXEC) begin
            casez (r_ir)
                4'b00??: begin
                    select_mode = r_ir[1:0];
                    ANSload     = 1'b1;
                end
                4'b0100: Aload = 1'b1;
                4'b0101: Bload = 1'b1;
                4'b0110: begin
                    A_select = 1'b1;
                    Aload    = 1'b1;
                end
                4'b0111: begin
                    B_select = 1'b1;
                    Bload    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign rom_addr    = r_pc;
    assign IRCU        = r_ir;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit with a ROM array and hand-computed per-cycle output tables.
module tb_cpu_control_unit;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic       step;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] IRCU;
  logic       Aload, Bload, ANSload, A_select, B_select;
  logic [1:0] select_mode;
  logic       busy, done;
  logic [2:0] o_dbg_state;

  logic [3:0] rom [16];
  int n_total = 0;
  int n_bad   = 0;

  // packed view: {busy, done, Aload, Bload, ANSload, A_select, B_select, select_mode}
  logic [8:0] exp_p1 [12];
  logic [8:0] exp_p2 [12];

  assign rom_data = rom[rom_addr];

  cpu_control_unit #(.RESET_PC(4'h0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
`ifdef CU_SINGLE_STEP_EN
    .step        (step),
`endif
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .IRCU        (IRCU),
    .Aload       (Aload),
    .Bload       (Bload),
    .ANSload     (ANSload),
    .A_select    (A_select),
    .B_select    (B_select),
    .select_mode (select_mode),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {busy, done, Aload, Bload, ANSload, A_select, B_select, select_mode};
  endfunction

  task automatic do_reset();
    Reset = 1'b0;
    start = 1'b0;
    step  = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
  endtask

  task automatic load_rom(input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] a2, input logic [3:0] a3);
    for (int i = 0; i < 16; i++) rom[i] = 4'h8;
    rom[0] = a0;
    rom[1] = a1;
    rom[2] = a2;
    rom[3] = a3;
  endtask

  // start sampled at edge 0; on return we are in cycle 1
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // 4-instruction program trace: cycles 1..11 against table, optional start held during cycles 1..7
  task automatic run_trace(input string name, input int which, input bit hold_start);
    logic [8:0] e;
    logic [3:0] ea;
    for (int c = 1; c <= 11; c++) begin
      e  = (which == 1) ? exp_p1[c] : exp_p2[c];
      ea = (c <= 8) ? 4'(c / 2) : 4'd4;
      chk($sformatf("%s_outs_c%0d", name, c), 16'(outs()), 16'(e));
      chk($sformatf("%s_addr_c%0d", name, c), 16'(rom_addr), 16'(ea));
      start = (hold_start && c <= 7);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    bit busy_all;
    bit done_seen;
    exp_p1 = '{9'h000, 9'h100, 9'h140, 9'h100, 9'h120, 9'h100, 9'h110,
               9'h100, 9'h100, 9'h180, 9'h000, 9'h000};
    exp_p2 = '{9'h000, 9'h100, 9'h111, 9'h100, 9'h148, 9'h100, 9'h112,
               9'h100, 9'h100, 9'h180, 9'h000, 9'h000};
    load_rom(4'b0100, 4'b0101, 4'b0000, 4'b1001);
    do_reset();

    // reset state
    chk("rst_outs", 16'(outs()), 16'h0);
    chk("rst_ir", 16'(IRCU), 16'h8);
    chk("rst_addr", 16'(rom_addr), 16'h0);
    chk("rst_state", 16'(o_dbg_state), 16'd0);

    // asynchronous reset in the middle of an EXEC with Aload high
    launch();
    tick();
    chk("mid_exec_aload", 16'(Aload), 16'h1);
    chk("mid_exec_state", 16'(o_dbg_state), 16'd2);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_outs", 16'(outs()), 16'h0);
    chk("async_ir", 16'(IRCU), 16'h8);
    chk("async_addr", 16'(rom_addr), 16'h0);
    chk("async_state", 16'(o_dbg_state), 16'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

`ifndef CU_SINGLE_STEP_EN
    // program 1: LDA_IN, LDB_IN, ADD, HALT
    do_reset();
    launch();
    run_trace("p1", 1, 1'b0);
    chk("p1_ir_last", 16'(IRCU), 16'h9);

    // program 2: ALU 01, LDA_ANS, ALU 10, HALT
    load_rom(4'b0001, 4'b0110, 4'b0010, 4'b1001);
    do_reset();
    launch();
    run_trace("p2", 2, 1'b0);

    // start held while busy must not disturb program 1
    load_rom(4'b0100, 4'b0101, 4'b0000, 4'b1001);
    do_reset();
    launch();
    run_trace("p1hold", 1, 1'b1);

    // PC wrap: NOPs with JMP0 at address 15
    load_rom(4'h8, 4'h8, 4'h8, 4'h8);
    rom[15] = 4'b1010;
    do_reset();
    launch();
    busy_all  = 1'b1;
    done_seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c % 2 == 1 && c <= 33)
        chk($sformatf("wrap_addr_c%0d", c), 16'(rom_addr), 16'(((c - 1) / 2) % 16));
      if (!busy) busy_all = 1'b0;
      if (done) done_seen = 1'b1;
      tick();
    end
    chk("wrap_busy_all", 16'(busy_all), 16'h1);
    chk("wrap_no_done", 16'(done_seen), 16'h0);
`else
    // single-step: LDA_IN then HALT
    load_rom(4'b0100, 4'b1001, 4'h8, 4'h8);
    do_reset();
    launch();
    chk("ss_fetch", 16'(o_dbg_state), 16'd1);
    tick();
    chk("ss_exec_aload", 16'(Aload), 16'h1);
    tick();
    for (int c = 3; c <= 12; c++) begin
      chk($sformatf("ss_pause_state_c%0d", c), 16'(o_dbg_state), 16'd4);
      chk($sformatf("ss_pause_outs_c%0d", c), 16'(outs()), 16'h100);
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("ss_fetch2", 16'(o_dbg_state), 16'd1);
    chk("ss_fetch2_addr", 16'(rom_addr), 16'h1);
    tick();
    chk("ss_exec_halt", 16'(o_dbg_state), 16'd2);
    tick();
    chk("ss_done", 16'(outs()), 16'h180);
    tick();
    chk("ss_idle", 16'(outs()), 16'h000);
    chk("ss_ir_last", 16'(IRCU), 16'h9);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
